// File: rtl/uart_msg_pkg.sv
// ---------------------------------------------------------------------------
// uart_msg_pkg
// Shared constants and helpers for the UART message formatter.
//   - ASCII bytes used in every frame (':' CR LF and the '0' digit base)
//   - frame lengths with and without the optional checksum
//   - FSM state encoding for uart_msg_tx
//   - bcd_adjust: the "add 3 to any nibble >= 5" step of double dabble
//   - hex_ascii : nibble to uppercase ASCII hex character
// Optional feature macro used by the consumers: UART_MSG_CHECKSUM_EN
// ---------------------------------------------------------------------------
package uart_msg_pkg;

   localparam logic [7:0] COLON = 8'h3A;
   localparam logic [7:0] CR    = 8'h0D;
   localparam logic [7:0] LF    = 8'h0A;
   localparam logic [7:0] ZERO  = 8'h30;

   localparam int FRAME_LEN_PLAIN = 8;
   localparam int FRAME_LEN_CSUM  = 10;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_CONV  = 3'd1;
   localparam logic [2:0] ST_START = 3'd2;
   localparam logic [2:0] ST_WAIT  = 3'd3;
   localparam logic [2:0] ST_DONE  = 3'd4;

   // Each BCD nibble that is 5 or more gets 3 added so that the following
   // left shift carries correctly into the next decimal digit.
   function automatic logic [15:0] bcd_adjust(input logic [15:0] v);
      logic [15:0] r;
      r = v;
      for (int i = 0; i < 4; i++) begin
         if (v[4*i +: 4] >= 4'd5) begin
            r[4*i +: 4] = v[4*i +: 4] + 4'd3;
         end
      end
      return r;
   endfunction

   // 0-9 map to '0'-'9', 10-15 map to 'A'-'F'.
   function automatic logic [7:0] hex_ascii(input logic [3:0] n);
      logic [7:0] r;
      if (n < 4'd10) begin
         r = 8'h30 + {4'h0, n};
      end else begin
         r = 8'h37 + {4'h0, n};
      end
      return r;
   endfunction

endpackage

// File: rtl/uart_msg_tx_bin2bcd_seq.sv
// ---------------------------------------------------------------------------
// bin2bcd_seq
// Sequential shift-add-3 (double dabble) binary to 4-digit BCD converter.
// A start pulse while idle loads the input; exactly VAL_W shift steps
// follow, one per clock. done is high during the final step's cycle, so bcd
// holds the finished result from the cycle after done onward and keeps it
// until the next start.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   start      load request (ignored while busy)
//   bin        VAL_W-bit binary input, must be <= 9999
//   busy       conversion in progress
//   done       final shift step occurs at the coming edge
//   bcd        4 BCD digits, d3 in [15:12]
// ---------------------------------------------------------------------------
module bin2bcd_seq
   import uart_msg_pkg::*;
#(
   parameter int VAL_W = 14
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [VAL_W-1:0] bin,
   output logic             busy,
   output logic             done,
   output logic [15:0]      bcd
);

   localparam int CNT_W = $clog2(VAL_W + 1);

   logic [VAL_W-1:0] shift_q;
   logic [CNT_W-1:0] cnt;
   logic [15:0]      adj;

   assign adj  = bcd_adjust(bcd);
   assign done = busy && (cnt == CNT_W'(VAL_W - 1));

   // One adjust-then-shift step per cycle, MSB of the binary first.
   always_ff @(posedge clk) begin
      if (rst) begin
         shift_q <= '0;
         bcd     <= '0;
         cnt     <= '0;
         busy    <= 1'b0;
      end else if (start && !busy) begin
         shift_q <= bin;
         bcd     <= '0;
         cnt     <= '0;
         busy    <= 1'b1;
      end else if (busy) begin
         {bcd, shift_q} <= {adj, shift_q} << 1;
         cnt            <= cnt + CNT_W'(1);
         if (done) begin
            busy <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/uart_msg_tx.sv
// ---------------------------------------------------------------------------
// uart_msg_tx
// Formats and sends "<tag>:<d3><d2><d1><d0>\r\n" to a UART transmitter, one
// byte per tx_start/tx_done handshake. The value is clamped to MAX_VAL and
// converted to decimal with bin2bcd_seq.
// Optional feature macro UART_MSG_CHECKSUM_EN: when defined, two uppercase
// hex characters holding the XOR of tag, ':' and the four digit bytes are
// inserted before CR LF (10-byte frame).
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   send            one-cycle request, taken only when idle
//   tag, value      frame contents, latched on accept
//   tx_busy         UART transmitter busy
//   tx_done         UART one-cycle byte-complete pulse
//   tx_start        one-cycle pulse launching tx_din
//   tx_din          registered byte for the UART
//   busy            frame in progress (accept until frame end)
//   frame_done      one-cycle pulse after the last byte completes
// ---------------------------------------------------------------------------
module uart_msg_tx
   import uart_msg_pkg::*;
#(
   parameter int VAL_W   = 14,
   parameter int MAX_VAL = 9999
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             send,
   input  logic [7:0]       tag,
   input  logic [VAL_W-1:0] value,
   input  logic             tx_busy,
   input  logic             tx_done,
   output logic             tx_start,
   output logic [7:0]       tx_din,
   output logic             busy,
   output logic             frame_done
);

`ifdef UART_MSG_CHECKSUM_EN
   localparam int FRAME_LEN = FRAME_LEN_CSUM;
`else
   localparam int FRAME_LEN = FRAME_LEN_PLAIN;
`endif

   logic [2:0]       state;
   logic [7:0]       tag_q;
   logic [3:0]       idx;
   logic [VAL_W-1:0] sat_value;
   logic             accept;
   logic             conv_busy;
   logic             conv_done;
   logic [15:0]      bcd;
   logic [3:0]       load_sel;
   logic [7:0]       frame_byte;

   // Out-of-range readings are clamped silently.
   always_comb begin
      sat_value = value;
      if (value > VAL_W'(MAX_VAL)) begin
         sat_value = VAL_W'(MAX_VAL);
      end
   end

   assign accept = (state == ST_IDLE) && send && !conv_busy;

   // The converter register doubles as the latched copy of the value.
   bin2bcd_seq #(
      .VAL_W (VAL_W)
   ) u_bin2bcd (
      .clk   (clk),
      .rst   (rst),
      .start (accept),
      .bin   (sat_value),
      .busy  (conv_busy),
      .done  (conv_done),
      .bcd   (bcd)
   );

   // tx_din is loaded on the way into START: byte 0 when leaving CONV,
   // otherwise the byte after the one just completed.
   assign load_sel = (state == ST_CONV) ? 4'd0 : idx + 4'd1;

`ifdef UART_MSG_CHECKSUM_EN
   logic [7:0] csum;

   assign csum = tag_q ^ COLON ^ {4'h3, bcd[15:12]} ^ {4'h3, bcd[11:8]}
               ^ {4'h3, bcd[7:4]} ^ {4'h3, bcd[3:0]};

   always_comb begin
      frame_byte = 8'h00;
      case (load_sel)
         4'd0:    frame_byte = tag_q;
         4'd1:    frame_byte = COLON;
         4'd2:    frame_byte = ZERO | {4'h0, bcd[15:12]};
         4'd3:    frame_byte = ZERO | {4'h0, bcd[11:8]};
         4'd4:    frame_byte = ZERO | {4'h0, bcd[7:4]};
         4'd5:    frame_byte = ZERO | {4'h0, bcd[3:0]};
         4'd6:    frame_byte = hex_ascii(csum[7:4]);
         4'd7:    frame_byte = hex_ascii(csum[3:0]);
         4'd8:    frame_byte = CR;
         4'd9:    frame_byte = LF;
         default: frame_byte = 8'h00;
      endcase
   end
`else
   always_comb begin
      frame_byte = 8'h00;
      case (load_sel)
         4'd0:    frame_byte = tag_q;
         4'd1:    frame_byte = COLON;
         4'd2:    frame_byte = ZERO | {4'h0, bcd[15:12]};
         4'd3:    frame_byte = ZERO | {4'h0, bcd[11:8]};
         4'd4:    frame_byte = ZERO | {4'h0, bcd[7:4]};
         4'd5:    frame_byte = ZERO | {4'h0, bcd[3:0]};
         4'd6:    frame_byte = CR;
         4'd7:    frame_byte = LF;
         default: frame_byte = 8'h00;
      endcase
   end
`endif

   // Frame sequencer. tx_start and frame_done are single-cycle pulses that
   // default low every cycle; CONV leaves on the converter's final step so
   // the first START evaluation happens one edge later.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         tag_q      <= 8'h00;
         idx        <= 4'd0;
         tx_start   <= 1'b0;
         tx_din     <= 8'h00;
         busy       <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         tx_start   <= 1'b0;
         frame_done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  tag_q <= tag;
                  idx   <= 4'd0;
                  busy  <= 1'b1;
                  state <= ST_CONV;
               end
            end
            ST_CONV: begin
               if (conv_done) begin
                  idx    <= 4'd0;
                  tx_din <= frame_byte;
                  state  <= ST_START;
               end
            end
            ST_START: begin
               if (!tx_busy) begin
                  tx_start <= 1'b1;
                  state    <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (tx_done) begin
                  if (idx == 4'(FRAME_LEN - 1)) begin
                     busy       <= 1'b0;
                     frame_done <= 1'b1;
                     state      <= ST_DONE;
                  end else begin
                     idx    <= idx + 4'd1;
                     tx_din <= frame_byte;
                     state  <= ST_START;
                  end
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_msg_tx.sv
// ---------------------------------------------------------------------------
// tb_uart_msg_tx
// Directed bench for uart_msg_tx with a simple UART transmitter model that
// captures every launched byte and answers with tx_done a few cycles later.
// Honors UART_MSG_CHECKSUM_EN for the expected frame layout.
// ---------------------------------------------------------------------------
module tb_uart_msg_tx;

   localparam int VAL_W = 14;
`ifdef UART_MSG_CHECKSUM_EN
   localparam int FLEN = 10;
`else
   localparam int FLEN = 8;
`endif

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             send = 1'b0;
   logic [7:0]       tag = 8'h00;
   logic [VAL_W-1:0] value = '0;
   logic             tx_busy = 1'b0;
   logic             tx_done = 1'b0;
   logic             tx_start;
   logic [7:0]       tx_din;
   logic             busy;
   logic             frame_done;

   int vector_count = 0;
   int miss_count   = 0;

   logic [7:0] sent_q[$];
   int         fd_count   = 0;
   int         stable_err = 0;
   logic       hold_busy  = 1'b0;
   logic       uart_busy  = 1'b0;
   int         uart_cnt   = 0;
   logic [7:0] held_byte  = 8'h00;

   uart_msg_tx #(
      .VAL_W   (VAL_W),
      .MAX_VAL (9999)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .send       (send),
      .tag        (tag),
      .value      (value),
      .tx_busy    (tx_busy),
      .tx_done    (tx_done),
      .tx_start   (tx_start),
      .tx_din     (tx_din),
      .busy       (busy),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   // UART model: a launched byte keeps the line busy for four cycles, then
   // tx_done pulses for one cycle. hold_busy lets a test stall the line.
   always @(negedge clk) begin
      tx_done = 1'b0;
      if (uart_busy) begin
         if (tx_din !== held_byte) stable_err++;
         if (uart_cnt == 0) begin
            tx_done   = 1'b1;
            uart_busy = 1'b0;
         end else begin
            uart_cnt--;
         end
      end
      if (tx_start === 1'b1) begin
         sent_q.push_back(tx_din);
         held_byte = tx_din;
         uart_busy = 1'b1;
         uart_cnt  = 3;
      end
      if (frame_done === 1'b1) fd_count++;
      tx_busy = uart_busy | hold_busy;
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] observed,
                              input logic [31:0] expected);
      vector_count++;
      if (observed !== expected) begin
         miss_count++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, observed, expected);
      end
   endtask

   // One-cycle send pulse; returns just after the accepting edge.
   task automatic applyStimulus(input logic [7:0] t, input int v);
      send  = 1'b1;
      tag   = t;
      value = VAL_W'(v);
      tick();
      send  = 1'b0;
   endtask

   // Returns in the cycle frame_done is observed, or reports a timeout.
   task automatic waitFrame(input string name, input int budget);
      int start_fd;
      int n;
      start_fd = fd_count;
      n = 0;
      while (fd_count == start_fd && n < budget) begin
         tick();
         n++;
      end
      checkOutput({name, "_frame_done_seen"}, fd_count - start_fd, 1);
      checkOutput({name, "_busy_at_frame_done"}, busy, 1'b0);
   endtask

   function automatic logic [7:0] hex_char(input logic [3:0] n);
      return (n < 4'd10) ? 8'(8'h30 + n) : 8'(8'h37 + n);
   endfunction

   task automatic checkFrame(input string name, input logic [7:0] t, input int v);
      int         sat;
      logic [7:0] exp_b[10];
      logic [7:0] cs;
      sat = (v > 9999) ? 9999 : v;
      exp_b[0] = t;
      exp_b[1] = 8'h3A;
      exp_b[2] = 8'(8'h30 + sat / 1000);
      exp_b[3] = 8'(8'h30 + (sat / 100) % 10);
      exp_b[4] = 8'(8'h30 + (sat / 10) % 10);
      exp_b[5] = 8'(8'h30 + sat % 10);
      cs = exp_b[0] ^ exp_b[1] ^ exp_b[2] ^ exp_b[3] ^ exp_b[4] ^ exp_b[5];
`ifdef UART_MSG_CHECKSUM_EN
      exp_b[6] = hex_char(cs[7:4]);
      exp_b[7] = hex_char(cs[3:0]);
      exp_b[8] = 8'h0D;
      exp_b[9] = 8'h0A;
`else
      exp_b[6] = 8'h0D;
      exp_b[7] = 8'h0A;
      exp_b[8] = 8'h00;
      exp_b[9] = 8'h00;
`endif
      checkOutput({name, "_len"}, sent_q.size(), FLEN);
      for (int i = 0; i < FLEN && i < sent_q.size(); i++) begin
         checkOutput($sformatf("%s_byte%0d", name, i), sent_q[i], exp_b[i]);
      end
      checkOutput({name, "_tx_din_stable"}, stable_err, 0);
   endtask

   initial begin
      int n;
      int fd_before;

      // Reset values
      rst = 1'b1;
      repeat (3) tick();
      checkOutput("rst_tx_start", tx_start, 1'b0);
      checkOutput("rst_tx_din", tx_din, 8'h00);
      checkOutput("rst_busy", busy, 1'b0);
      checkOutput("rst_frame_done", frame_done, 1'b0);
      rst = 1'b0;
      repeat (2) tick();

      // T:1234 with first-launch latency and single frame_done pulse
      sent_q.delete();
      stable_err = 0;
      fd_before = fd_count;
      applyStimulus(8'h54, 1234);
      checkOutput("t1_busy_after_accept", busy, 1'b1);
      n = 1;
      tick();
      while (tx_start !== 1'b1 && n < 100) begin
         tick();
         n++;
      end
      checkOutput("t1_first_start_latency", n, 15);
      waitFrame("t1", 300);
      checkFrame("t1", 8'h54, 1234);
`ifdef UART_MSG_CHECKSUM_EN
      checkOutput("t1_csum_hi", sent_q[6], 8'h36);
      checkOutput("t1_csum_lo", sent_q[7], 8'h41);
`endif
      repeat (5) tick();
      checkOutput("t1_frame_done_once", fd_count - fd_before, 1);

      // Saturation and zero
      sent_q.delete();
      stable_err = 0;
      applyStimulus(8'h54, 12000);
      waitFrame("sat", 300);
      checkFrame("sat", 8'h54, 12000);
      checkOutput("sat_d0", sent_q[5], 8'h39);
      repeat (3) tick();

      sent_q.delete();
      stable_err = 0;
      applyStimulus(8'h5A, 0);
      waitFrame("zero", 300);
      checkFrame("zero", 8'h5A, 0);
      checkOutput("zero_d3", sent_q[2], 8'h30);
      repeat (3) tick();

      // UART held busy for 50 cycles: nothing launches, tag is preloaded
      sent_q.delete();
      stable_err = 0;
      hold_busy = 1'b1;
      applyStimulus(8'h42, 567);
      repeat (50) tick();
      checkOutput("stall_no_start", sent_q.size(), 0);
      checkOutput("stall_tx_din_preload", tx_din, 8'h42);
      hold_busy = 1'b0;
      waitFrame("stall", 300);
      checkFrame("stall", 8'h42, 567);
      repeat (3) tick();

      // Mid-frame send ignored; send the cycle after frame_done accepted
      sent_q.delete();
      stable_err = 0;
      applyStimulus(8'h48, 4321);
      repeat (30) tick();
      applyStimulus(8'h41, 5555);
      waitFrame("midsend", 300);
      checkFrame("midsend", 8'h48, 4321);
      tick();
      sent_q.delete();
      stable_err = 0;
      applyStimulus(8'h4E, 9);
      checkOutput("backtoback_busy", busy, 1'b1);
      waitFrame("backtoback", 300);
      checkFrame("backtoback", 8'h4E, 9);
      repeat (3) tick();

      // Reset while waiting on byte 3
      sent_q.delete();
      applyStimulus(8'h52, 8888);
      n = 0;
      while (sent_q.size() < 4 && n < 300) begin
         tick();
         n++;
      end
      checkOutput("rstmid_reached_byte3", sent_q.size(), 4);
      fd_before = fd_count;
      rst = 1'b1;
      tick();
      checkOutput("rstmid_tx_start", tx_start, 1'b0);
      checkOutput("rstmid_tx_din", tx_din, 8'h00);
      checkOutput("rstmid_busy", busy, 1'b0);
      checkOutput("rstmid_frame_done", frame_done, 1'b0);
      rst = 1'b0;
      repeat (40) tick();
      checkOutput("rstmid_no_more_start", sent_q.size(), 4);
      checkOutput("rstmid_no_frame_done", fd_count - fd_before, 0);
      sent_q.delete();
      stable_err = 0;
      applyStimulus(8'h46, 2468);
      waitFrame("fresh", 300);
      checkFrame("fresh", 8'h46, 2468);
      repeat (3) tick();

      $display("== %0d vectors applied, %0d miscompares ==", vector_count, miss_count);
      $finish;
   end

endmodule
